// File: rtl/sram_frame_arbiter.sv
// rtl/sram_frame_arbiter.sv - ping-pong frame buffer arbiter for a shared 16-bit async SRAM
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   i_wr_valid/i_wr_data        camera pixel stream into the write FIFO
//   i_wr_sof                    camera start of frame (completes or discards the frame)
//   o_wr_overflow               sticky: a pixel was dropped because the FIFO was full
//   i_rd_req, i_rd_sof          display read request / display start of frame
//   o_rd_valid, o_rd_data       read pixel, two cycles after its request
//   o_frame_valid               at least one complete frame is in SRAM
//   SRAM_*                      SRAM pins; this block is their only driver
`timescale 1ns/1ps
module sram_frame_arbiter #(
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_valid,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_sof,
  output logic        o_wr_overflow,
  input  logic        i_rd_req,
  input  logic        i_rd_sof,
  output logic        o_rd_valid,
  output logic [15:0] o_rd_data,
  output logic        o_frame_valid,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int          PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FIFO_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [19:0] FRAME_FULL = 20'(FRAME_WORDS);
  localparam logic [18:0] LAST_OFS   = 19'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state_q, state_d;

  // write FIFO: address is resolved at push time so a later bank swap
  // cannot redirect pixels that are already queued
  logic [19:0]   fifo_addr [FIFO_DEPTH];
  logic [15:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;

  logic        wb, lb, rb;
  logic [18:0] wo, ro;
  logic [19:0] wc;
  logic [15:0] dq_out;

  // same-cycle sof takes effect before the push / read it accompanies
  logic        wb_eff, rb_eff;
  logic [18:0] wo_eff, ro_eff;
  logic [19:0] wc_eff;
  logic        push, drop_full, pop;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = SRAM_WE_N ? 16'hzzzz : dq_out;

  always_comb begin
    wb_eff    = wb;
    wo_eff    = wo;
    wc_eff    = wc;
    push      = 1'b0;
    drop_full = 1'b0;
    if (i_wr_sof) begin
      wo_eff = '0;
      wc_eff = '0;
      if (wc == FRAME_FULL) wb_eff = ~wb;
    end
    // a full frame swallows extra pixels silently; only a full FIFO is an overflow
    if (i_wr_valid && (wc_eff != FRAME_FULL)) begin
      if (fifo_count == FIFO_FULL) drop_full = 1'b1;
      else                         push      = 1'b1;
    end
    rb_eff = i_rd_sof ? lb : rb;
    ro_eff = i_rd_sof ? '0 : ro;
  end

  // reads have absolute priority; writes wait in the FIFO
  always_comb begin
    state_d = IDLE;
    pop     = 1'b0;
    if (i_rd_req) begin
      state_d = RD;
    end else if (fifo_count != '0) begin
      state_d = WR;
      pop     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= {wb_eff, wo_eff};
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb            <= 1'b0;
      lb            <= 1'b0;
      wo            <= '0;
      wc            <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      o_frame_valid <= 1'b0;
      o_wr_overflow <= 1'b0;
    end else begin
      if (i_wr_sof && (wc == FRAME_FULL)) begin
        lb            <= wb;
        o_frame_valid <= 1'b1;
      end
      wb <= wb_eff;
      if (push) begin
        wo     <= wo_eff + 19'd1;
        wc     <= wc_eff + 20'd1;
        wr_ptr <= wr_ptr + PW'(1);
      end else begin
        wo <= wo_eff;
        wc <= wc_eff;
      end
      if (drop_full) o_wr_overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (PW+1)'(1);
      else if (!push && pop) fifo_count <= fifo_count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb         <= 1'b0;
      ro         <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      dq_out     <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      rb         <= rb_eff;
      ro         <= ro_eff;
      o_rd_valid <= (state_q == RD);
      if (state_q == RD) o_rd_data <= SRAM_DQ;
      SRAM_WE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      // address, data and WE_N switch on the same edge: the SRAM has zero setup/hold
      case (state_d)
        RD: begin
          SRAM_ADDR <= {rb_eff, ro_eff};
          SRAM_OE_N <= 1'b0;
          ro        <= (ro_eff == LAST_OFS) ? '0 : ro_eff + 19'd1;
        end
        WR: begin
          SRAM_ADDR <= fifo_addr[rd_ptr];
          dq_out    <= fifo_data[rd_ptr];
          SRAM_WE_N <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// tb/tb_sram_frame_arbiter.sv - directed self-checking bench for sram_frame_arbiter
`timescale 1ns/1ps
module tb_sram_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wr_valid, i_wr_sof, i_rd_req, i_rd_sof;
  logic [15:0] i_wr_data;
  logic        o_wr_overflow, o_rd_valid, o_frame_valid;
  logic [15:0] o_rd_data;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int req_cyc;

  logic [15:0] mem [8];
  logic [2:0]  midx;
  logic [35:0] wr_log [$];
  logic [15:0] rd_log [$];
  int          rd_cyc [$];
  logic [35:0] exp_wr [4];

  sram_frame_arbiter #(.FRAME_WORDS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .i_wr_sof(i_wr_sof),
    .o_wr_overflow(o_wr_overflow),
    .i_rd_req(i_rd_req), .i_rd_sof(i_rd_sof),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_frame_valid(o_frame_valid),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: only offsets 0..3 of each bank are ever touched
  assign midx    = {sram_addr[19], sram_addr[1:0]};
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[midx] : 16'hzzzz;

  always @(negedge clk) begin
    if (!sram_we_n) begin
      mem[midx] = sram_dq;
      wr_log.push_back({sram_addr, sram_dq});
    end
    if (o_rd_valid) begin
      rd_log.push_back(o_rd_data);
      rd_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_sof = 1'b0; i_wr_data = '0;
    i_rd_req = 1'b0; i_rd_sof = 1'b0;
    repeat (3) step();
    check("rst_we_n",     36'(sram_we_n), 36'd1);
    check("rst_oe_n",     36'(sram_oe_n), 36'd1);
    check("rst_addr",     36'(sram_addr), 36'd0);
    check("rst_rd_valid", 36'(o_rd_valid), 36'd0);
    check("rst_frame_v",  36'(o_frame_valid), 36'd0);
    check("rst_ovf",      36'(o_wr_overflow), 36'd0);
    rst_n = 1'b1;

    // reset asserted in the middle of a WR cycle
    i_wr_valid = 1'b1; i_wr_data = 16'h1234; step();
    i_wr_valid = 1'b0; step();
    check("wr_active_we", 36'(sram_we_n), 36'd0);
    wr_log.delete();
    #2 rst_n = 1'b0;
    #1;
    check("rst_abort_we", 36'(sram_we_n), 36'd1);
    step();
    check("rst_no_write", 36'(wr_log.size()), 36'd0);
    step();
    rst_n = 1'b1;

    // frame write and bank swap
    wr_log.delete();
    i_wr_sof = 1'b1; step(); i_wr_sof = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 16'(16'hA000 + i); step();
    end
    i_wr_valid = 1'b0; i_wr_sof = 1'b1; step(); i_wr_sof = 1'b0;
    check("frame_valid_set", 36'(o_frame_valid), 36'd1);
    i_wr_valid = 1'b1; i_wr_data = 16'hB000; step(); i_wr_valid = 1'b0;
    repeat (4) step();
    check("s2_wr_count", 36'(wr_log.size()), 36'd5);
    for (int i = 0; i < 4; i++)
      check("s2_wr_entry", wr_log[i], {20'(i), 16'(16'hA000 + i)});
    check("s2_bank1_wr", wr_log[4], {20'h80000, 16'hB000});

    // read-back with latency and offset wrap
    rd_log.delete(); rd_cyc.delete();
    i_rd_sof = 1'b1; step(); i_rd_sof = 1'b0;
    req_cyc = cyc;
    i_rd_req = 1'b1; repeat (5) step(); i_rd_req = 1'b0;
    repeat (3) step();
    check("s3_rd_count", 36'(rd_log.size()), 36'd5);
    for (int i = 0; i < 5; i++) begin
      check("s3_rd_data", 36'(rd_log[i]), 36'((i < 4) ? 16'hA000 + i : 16'hA000));
      check("s3_rd_lat",  36'(rd_cyc[i]), 36'(req_cyc + 2 + i));
    end

    // read priority and FIFO overflow (sof on the 3rd pixel restarts the count)
    wr_log.delete();
    i_rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 16'(16'hC000 + i); i_wr_sof = (i == 2);
      step();
      if (i == 3) check("s4_no_ovf_yet", 36'(o_wr_overflow), 36'd0);
      if (i == 4) check("s4_ovf_set",    36'(o_wr_overflow), 36'd1);
    end
    i_wr_valid = 1'b0; i_wr_sof = 1'b0;
    check("s4_no_wr_under_rd", 36'(wr_log.size()), 36'd0);
    i_rd_req = 1'b0;
    repeat (8) step();
    exp_wr[0] = {20'h80001, 16'hC000};
    exp_wr[1] = {20'h80002, 16'hC001};
    exp_wr[2] = {20'h80000, 16'hC002};
    exp_wr[3] = {20'h80001, 16'hC003};
    check("s4_drain_count", 36'(wr_log.size()), 36'd4);
    for (int i = 0; i < 4; i++) check("s4_drain_entry", wr_log[i], exp_wr[i]);
    check("s4_ovf_sticky", 36'(o_wr_overflow), 36'd1);

    // partial frame discarded, extra pixel in a full frame dropped silently
    rst_n = 1'b0; step(); rst_n = 1'b1;
    wr_log.delete();
    i_wr_valid = 1'b1; i_wr_data = 16'hD000; step();
    i_wr_data = 16'hD001; step();
    i_wr_valid = 1'b0; i_wr_sof = 1'b1; step(); i_wr_sof = 1'b0;
    check("s5_frame_v_low", 36'(o_frame_valid), 36'd0);
    for (int i = 0; i < 5; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 16'(16'hE000 + i); step();
    end
    i_wr_valid = 1'b0;
    repeat (6) step();
    check("s5_wr_count",  36'(wr_log.size()), 36'd6);
    check("s5_partial0",  wr_log[0], {20'h00000, 16'hD000});
    check("s5_same_bank", wr_log[2], {20'h00000, 16'hE000});
    check("s5_last",      wr_log[5], {20'h00003, 16'hE003});
    check("s5_no_ovf",    36'(o_wr_overflow), 36'd0);
    check("s5_frame_v",   36'(o_frame_valid), 36'd0);

    // simultaneous sof with pixel / request
    wr_log.delete(); rd_log.delete();
    i_wr_sof = 1'b1; i_wr_valid = 1'b1; i_wr_data = 16'hF000; step();
    i_wr_sof = 1'b0;
    check("s6_frame_v", 36'(o_frame_valid), 36'd1);
    for (int i = 1; i < 4; i++) begin
      i_wr_data = 16'(16'hF000 + i); step();
    end
    i_wr_valid = 1'b0; i_wr_sof = 1'b1; step(); i_wr_sof = 1'b0;
    repeat (4) step();
    check("s6_sof_pixel", wr_log[0], {20'h80000, 16'hF000});
    check("s6_last_pix",  wr_log[3], {20'h80003, 16'hF003});
    i_rd_req = 1'b1; step();
    check("s6_rd_old_bank", 36'(sram_addr), 36'h00000);
    i_rd_sof = 1'b1; step();
    check("s6_rd_new_addr", 36'(sram_addr), 36'h80000);
    check("s6_rd_oe",       36'(sram_oe_n), 36'd0);
    i_rd_req = 1'b0; i_rd_sof = 1'b0;
    repeat (3) step();
    check("s6_rd_count", 36'(rd_log.size()), 36'd2);
    check("s6_rd_data",  36'(rd_log[1]), 36'h0F000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_frame_arbiter.md
Name: sram_frame_arbiter

Overview:
- Shares the single off-chip 16-bit asynchronous SRAM (1M x 16, 20-bit address) between two requesters:
  - the camera pixel stream, which writes;
  - the display scan-out, which reads.
- Holds two frame buffers in SRAM in ping-pong fashion. The display always reads the most recently completed frame while the camera fills the other one.
- Sits between the CCD capture path and the VGA controller. It is the only block that drives the SRAM pins.

Parameters:
- FRAME_WORDS, 307200, pixels per frame (640x480); must be at most 524288.
- FIFO_DEPTH, 8, write-FIFO entries; must be a power of two.

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous reset, active low
- i_wr_valid  input  1  camera pixel valid (DVAL)
- i_wr_data  input  16  camera pixel
- i_wr_sof  input  1  camera start-of-frame pulse
- o_wr_overflow  output  1  sticky: a pixel was dropped because the FIFO was full
- i_rd_req  input  1  display read request, at most one per cycle
- i_rd_sof  input  1  display start-of-frame pulse
- o_rd_valid  output  1  read data valid
- o_rd_data  output  16  read pixel
- o_frame_valid  output  1  at least one complete frame has been written
- SRAM_ADDR  output  20  SRAM address, {bank, offset[18:0]}
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0
- SRAM_OE_N  output  1  SRAM output enable, active low
- SRAM_WE_N  output  1  SRAM write enable, active low

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active low.
- Reset values:
  - SRAM_ADDR=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z.
  - o_rd_valid=0, o_rd_data=0, o_wr_overflow=0, o_frame_valid=0.
  - FIFO empty; write bank wb=0; last-full bank lb=0; read bank rb=0.
  - Write offset wo=0, write count wc=0, read offset ro=0.
- Reset mid-access: aborts the access immediately. No write may complete after rst_n falls.
- Write-side address generation happens at push time. Each FIFO entry holds {20-bit addr, 16-bit data}.
- i_wr_sof, evaluated before any same-cycle push:
  - If wc==FRAME_WORDS: lb<=wb, wb<=~wb, o_frame_valid<=1.
  - Otherwise the partial frame is discarded and wb is kept.
  - In both cases wo<=0 and wc<=0.
  - A pixel in the same cycle as i_wr_sof is offset 0 of the new frame.
- Push on i_wr_valid:
  - If wc==FRAME_WORDS, drop silently; no overflow is flagged.
  - Else if the FIFO is full (judged on the pre-pop count), drop and set o_wr_overflow. o_wr_overflow clears only on reset.
  - Else push {wb, wo}, then wo++ and wc++.
- Arbiter FSM, states IDLE, RD, WR, re-evaluated every cycle:
  - i_rd_req=1 -> RD (reads have absolute priority).
  - Else FIFO non-empty -> WR.
  - Else -> IDLE.
- Every access takes exactly one cycle, so back-to-back accesses in any mix are allowed.
- RD entry, registered at the clock edge:
  - SRAM_ADDR<={rb, ro}, OE_N<=0, WE_N<=1, DQ released.
  - ro increments and wraps from FRAME_WORDS-1 to 0.
- In the RD cycle, SRAM_DQ is captured into o_rd_data at the next edge and o_rd_valid<=1 for one cycle.
- Read latency: request in cycle N gives o_rd_valid in cycle N+2. One valid per request, in order.
- i_rd_sof: rb<=lb and ro<=0 before any same-cycle request, so that request reads offset 0 of the new bank.
- WR entry, registered at the clock edge:
  - Pop the FIFO.
  - SRAM_ADDR<=entry.addr, WE_N<=0, OE_N<=1.
  - DQ is driven with entry.data.
- SRAM_DQ is driven if and only if the registered WE_N is 0. It is high-Z in all other states.
- Write timing: address, data and WE_N all change on the same edge. This is legal because the SRAM has tAS=tHA=0.
- IDLE: WE_N=1, OE_N=1, DQ high-Z. SRAM_ADDR holds its last value.
- FIFO behaviour:
  - Push and pop in the same cycle with the FIFO non-full keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Writes starve while i_rd_req stays high. The FIFO absorbs this; overflow is flagged as above.

Test Plan:
Run with FRAME_WORDS=4 and FIFO_DEPTH=4, with an SRAM behavioural model on the bus.
1. Post-reset state: hold rst_n low, then release -> SRAM_WE_N=1, SRAM_OE_N=1, DQ=Z, o_rd_valid=0, o_frame_valid=0. Assert rst_n low during a WR cycle -> WE_N returns to 1 asynchronously.
2. Frame write and bank swap: i_wr_sof, then pixels 0xA000..0xA003 on consecutive cycles, then i_wr_sof again -> WR cycles at SRAM addresses 0x00000..0x00003, o_frame_valid=1, wb=1. The next pixel 0xB000 is written at 0x80000.
3. Read-back with latency: after scenario 2, i_rd_sof and then i_rd_req on 4 consecutive cycles -> o_rd_valid in cycles N+2..N+5 with data 0xA000..0xA003. A fifth request returns 0xA000 (offset wrap).
4. Read priority and overflow: hold i_rd_req=1 while pushing 6 pixels -> no WR cycles occur, the FIFO holds 4 entries, and o_wr_overflow=1 after the 5th pixel. Drop i_rd_req -> exactly 4 WR cycles drain the FIFO in order.
5. Partial frame discarded: write 2 pixels, pulse i_wr_sof -> wb is unchanged and o_frame_valid stays 0. A 5th pixel within a full frame (wc==4) is dropped without setting o_wr_overflow.
6. Simultaneous events: i_rd_sof together with i_rd_req, and i_wr_sof together with i_wr_valid -> the read uses {new rb, 0} and the pixel is stored at {new wb, 0}.
